// File: rtl/wu_decode.sv
// wu_decode: skid FIFO + descriptor parser between WU memory read data and
// the manager dispatch logic. One decoded word per valid/ready handshake.
module wu_decode #(
    parameter int WU_DATA_WIDTH = 64,
    parameter int FIFO_DEPTH    = 8,
    parameter int SKID          = 4
) (
    input  logic                     clk,
    input  logic                     reset_poweron,
    input  logic                     mcntl__wud__enable,
    input  logic                     wum__wud__valid,
    input  logic [WU_DATA_WIDTH-1:0] wum__wud__data,
    output logic                     wud__wuf__stall,
    output logic                     wud__xxx__valid,
    input  logic                     xxx__wud__ready,
    output logic [3:0]               wud__xxx__op,
    output logic [11:0]              wud__xxx__tag,
    output logic [3:0]               wud__xxx__opt_type,
    output logic [31:0]              wud__xxx__opt_value,
    output logic                     wud__xxx__sop,
    output logic                     wud__xxx__eop,
    output logic                     wud__mcntl__err,
    output logic                     wud__mcntl__halted
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_DESC   = 4'h1;
    localparam logic [3:0] OP_OPTION = 4'h2;
    localparam logic [3:0] OP_END    = 4'h3;
    localparam logic [3:0] OP_HALT   = 4'hF;

    typedef enum logic [1:0] {S_IDLE, S_IN_DESC, S_HALTED, S_ERR} state_t;

    logic [WU_DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [11:0]   tag_q, tag_d;
    logic          vld_q, vld_d;
    logic [3:0]    op_q, op_d;
    logic [11:0]   otag_q, otag_d;
    logic [3:0]    otype_q, otype_d;
    logic [31:0]   oval_q, oval_d;
    logic          sop_q, sop_d, eop_q, eop_d;
    logic          err_q, err_d, halted_q, halted_d, stall_q, stall_d;

    logic                     fifo_empty, fifo_full, bypass, head_vld, slot, accept;
    logic [WU_DATA_WIDTH-1:0] head_data;
    logic [3:0]               head_op;
    logic                     pop, pop_fifo, push, do_wr, proto_err, load;
    logic                     unused_bits;

    // When the FIFO is empty the incoming word is decoded directly (fall-through).
    assign fifo_empty  = (occ_q == '0);
    assign fifo_full   = (occ_q == CW'(FIFO_DEPTH));
    assign bypass      = fifo_empty;
    assign head_vld    = fifo_empty ? wum__wud__valid : 1'b1;
    assign head_data   = fifo_empty ? wum__wud__data : fifo_mem[rd_ptr_q];
    assign head_op     = head_data[63:60];
    assign slot        = ~vld_q | xxx__wud__ready;
    assign accept      = vld_q & xxx__wud__ready;
    assign unused_bits = ^head_data[47:32];

    // Decode the head word, advance the FSM, FIFO pointers and output slice.
    always_comb begin
        state_d   = state_q;
        tag_d     = tag_q;
        vld_d     = vld_q & ~accept;
        op_d      = op_q;
        otag_d    = otag_q;
        otype_d   = otype_q;
        oval_d    = oval_q;
        sop_d     = sop_q;
        eop_d     = eop_q;
        err_d     = err_q;
        halted_d  = halted_q | (accept & (op_q == OP_HALT));
        pop       = 1'b0;
        load      = 1'b0;
        proto_err = 1'b0;

        if (head_vld && (state_q == S_IDLE || state_q == S_IN_DESC)) begin
            case (head_op)
                OP_NOP: pop = 1'b1;
                OP_DESC: begin
                    if (state_q != S_IDLE) proto_err = 1'b1;
                    else if (slot) begin
                        load    = 1'b1;
                        state_d = S_IN_DESC;
                        tag_d   = head_data[59:48];
                    end
                end
                OP_OPTION, OP_END: begin
                    if (state_q != S_IN_DESC) proto_err = 1'b1;
                    else if (slot) begin
                        load = 1'b1;
                        if (head_op == OP_END) state_d = S_IDLE;
                    end
                end
                OP_HALT: begin
                    if (state_q != S_IDLE) proto_err = 1'b1;
                    else if (slot) begin
                        load    = 1'b1;
                        state_d = S_HALTED;
                    end
                end
                default: proto_err = 1'b1;
            endcase
        end

        if (load) begin
            pop     = 1'b1;
            vld_d   = 1'b1;
            op_d    = head_op;
            otag_d  = (head_op == OP_DESC) ? head_data[59:48] : tag_q;
            otype_d = (head_op == OP_OPTION) ? head_data[59:56] : 4'h0;
            oval_d  = (head_op == OP_OPTION) ? head_data[31:0] : 32'h0;
            sop_d   = (head_op == OP_DESC);
            eop_d   = (head_op == OP_END);
        end

        // A bypassed word that is consumed never touches the FIFO.
        pop_fifo = pop & ~bypass;
        push     = wum__wud__valid & ~(bypass & pop);
        do_wr    = push & (~fifo_full | pop_fifo);

        if (proto_err || (push && !do_wr)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
        end

        wr_ptr_d = wr_ptr_q + AW'(do_wr);
        rd_ptr_d = rd_ptr_q + AW'(pop_fifo);
        occ_d    = occ_q + CW'(do_wr) - CW'(pop_fifo);

        if (!mcntl__wud__enable) begin
            do_wr    = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
            state_d  = S_IDLE;
            vld_d    = 1'b0;
            op_d     = 4'h0;
            otag_d   = 12'h0;
            otype_d  = 4'h0;
            oval_d   = 32'h0;
            sop_d    = 1'b0;
            eop_d    = 1'b0;
            err_d    = 1'b0;
            halted_d = 1'b0;
        end

        stall_d = (occ_d >= CW'(FIFO_DEPTH - SKID)) | halted_d | err_d
                | (state_d == S_HALTED);
        if (!mcntl__wud__enable) stall_d = 1'b0;
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_wr) fifo_mem[wr_ptr_q] <= wum__wud__data;
    end

    // State, pointers and output slice registers.
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            tag_q    <= '0;
            vld_q    <= 1'b0;
            op_q     <= '0;
            otag_q   <= '0;
            otype_q  <= '0;
            oval_q   <= '0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            err_q    <= 1'b0;
            halted_q <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            tag_q    <= tag_d;
            vld_q    <= vld_d;
            op_q     <= op_d;
            otag_q   <= otag_d;
            otype_q  <= otype_d;
            oval_q   <= oval_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            err_q    <= err_d;
            halted_q <= halted_d;
            stall_q  <= stall_d;
        end
    end

    assign wud__wuf__stall     = stall_q;
    assign wud__xxx__valid     = vld_q;
    assign wud__xxx__op        = op_q;
    assign wud__xxx__tag       = otag_q;
    assign wud__xxx__opt_type  = otype_q;
    assign wud__xxx__opt_value = oval_q;
    assign wud__xxx__sop       = sop_q;
    assign wud__xxx__eop       = eop_q;
    assign wud__mcntl__err     = err_q;
    assign wud__mcntl__halted  = halted_q;

endmodule

// File: tb/tb_wu_decode.sv
// Directed bench for wu_decode: vector table for streaming decode, plus
// hand sequences for flush, protocol error, back-pressure, overflow, reset.
module tb_wu_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        wvld = 1'b0;
    logic [63:0] wdata = 64'h0;
    logic        rdy = 1'b1;
    logic        stall, vld, sop, eop, err, halted;
    logic [3:0]  op, otype;
    logic [11:0] tag;
    logic [31:0] oval;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wu_decode dut (
        .clk(clk), .reset_poweron(rst), .mcntl__wud__enable(en),
        .wum__wud__valid(wvld), .wum__wud__data(wdata),
        .wud__wuf__stall(stall), .wud__xxx__valid(vld), .xxx__wud__ready(rdy),
        .wud__xxx__op(op), .wud__xxx__tag(tag), .wud__xxx__opt_type(otype),
        .wud__xxx__opt_value(oval), .wud__xxx__sop(sop), .wud__xxx__eop(eop),
        .wud__mcntl__err(err), .wud__mcntl__halted(halted)
    );

    typedef struct {
        logic        vld;
        logic [63:0] data;
        logic        e_vld;
        logic [3:0]  e_op;
        logic [11:0] e_tag;
        logic [3:0]  e_ot;
        logic [31:0] e_ov;
        logic        e_sop, e_eop, e_stall, e_halted, e_err;
    } vec_t;

    function automatic logic [63:0] w_desc(input logic [11:0] t);
        return {4'h1, t, 48'h0};
    endfunction
    function automatic logic [63:0] w_opt(input logic [3:0] t, input logic [31:0] v);
        return {4'h2, t, 24'h0, v};
    endfunction
    function automatic logic [63:0] w_end();
        return {4'h3, 28'h0, 32'hDEADBEEF};
    endfunction
    function automatic logic [63:0] w_nop();
        return 64'h0;
    endfunction
    function automatic logic [63:0] w_halt();
        return {4'hF, 60'h0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive one input word (or idle) and advance one clock; sample #1 later.
    task automatic step(input logic v, input logic [63:0] d);
        wvld  = v;
        wdata = d;
        @(posedge clk);
        #1;
    endtask

    vec_t vt[10];
    int   idx;

    initial begin
        // Reset state
        #2;
        chk("rst_valid", vld, 0);
        chk("rst_stall", stall, 0);
        chk("rst_tag", tag, 0);
        chk("rst_err", err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Streaming table, ready=1 throughout: word in at edge N shows at N.
        vt[0] = '{1, w_desc(12'h0A5),            1, 4'h1, 12'h0A5, 4'h0, 32'h0,        1, 0, 0, 0, 0};
        vt[1] = '{1, w_opt(4'h3, 32'h12345678),  1, 4'h2, 12'h0A5, 4'h3, 32'h12345678, 0, 0, 0, 0, 0};
        vt[2] = '{1, w_end(),                    1, 4'h3, 12'h0A5, 4'h0, 32'h0,        0, 1, 0, 0, 0};
        vt[3] = '{0, 64'h0,                      0, 4'h0, 12'h0,   4'h0, 32'h0,        0, 0, 0, 0, 0};
        vt[4] = '{1, w_desc(12'h123),            1, 4'h1, 12'h123, 4'h0, 32'h0,        1, 0, 0, 0, 0};
        vt[5] = '{1, w_nop(),                    0, 4'h0, 12'h0,   4'h0, 32'h0,        0, 0, 0, 0, 0};
        vt[6] = '{1, w_end(),                    1, 4'h3, 12'h123, 4'h0, 32'h0,        0, 1, 0, 0, 0};
        vt[7] = '{1, w_halt(),                   1, 4'hF, 12'h123, 4'h0, 32'h0,        0, 0, 1, 0, 0};
        vt[8] = '{0, 64'h0,                      0, 4'h0, 12'h0,   4'h0, 32'h0,        0, 0, 1, 1, 0};
        vt[9] = '{1, w_desc(12'h777),            0, 4'h0, 12'h0,   4'h0, 32'h0,        0, 0, 1, 1, 0};
        rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(vt[i].vld, vt[i].data);
            chk($sformatf("v%0d_valid", i), vld, vt[i].e_vld);
            if (vt[i].e_vld) begin
                chk($sformatf("v%0d_op", i), op, vt[i].e_op);
                chk($sformatf("v%0d_tag", i), tag, vt[i].e_tag);
                chk($sformatf("v%0d_opt_type", i), otype, vt[i].e_ot);
                chk($sformatf("v%0d_opt_value", i), oval, vt[i].e_ov);
                chk($sformatf("v%0d_sop", i), sop, vt[i].e_sop);
                chk($sformatf("v%0d_eop", i), eop, vt[i].e_eop);
            end
            chk($sformatf("v%0d_stall", i), stall, vt[i].e_stall);
            chk($sformatf("v%0d_halted", i), halted, vt[i].e_halted);
            chk($sformatf("v%0d_err", i), err, vt[i].e_err);
        end

        // Flush out of HALTED; the queued DESC must be discarded.
        en = 1'b0;
        step(0, 64'h0);
        chk("flush_halted", halted, 0);
        chk("flush_stall", stall, 0);
        chk("flush_valid", vld, 0);
        en = 1'b1;
        step(0, 64'h0);
        chk("flush_fifo_empty", vld, 0);

        // Protocol error: OPTION in IDLE.
        step(1, w_opt(4'h1, 32'h55));
        chk("perr_err", err, 1);
        chk("perr_valid", vld, 0);
        chk("perr_stall", stall, 1);
        step(0, 64'h0);
        chk("perr_sticky", err, 1);
        chk("perr_no_emit", vld, 0);
        en = 1'b0;
        step(0, 64'h0);
        chk("perr_clr_err", err, 0);
        chk("perr_clr_stall", stall, 0);
        en = 1'b1;
        step(1, w_desc(12'h0B0));
        chk("perr_idle_valid", vld, 1);
        chk("perr_idle_sop", sop, 1);
        chk("perr_idle_tag", tag, 12'h0B0);
        step(1, w_end());
        chk("perr_idle_eop", eop, 1);
        step(0, 64'h0);

        // Back-pressure: 8 words in with ready=0 for 10 cycles.
        rdy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 0) step(1, w_desc(12'h0C1));
            else if (k == 7) step(1, w_end());
            else step(1, w_opt(4'(k), 32'(k) * 32'h1111));
            chk($sformatf("bp%0d_hold_op", k), op, 4'h1);
            if (k == 3) chk("bp_stall_low", stall, 0);
            if (k == 4) chk("bp_stall_high", stall, 1);
        end
        step(0, 64'h0);
        step(0, 64'h0);
        chk("bp_hold_valid", vld, 1);
        chk("bp_hold_tag", tag, 12'h0C1);
        rdy = 1'b1;
        idx = 0;
        for (int c = 0; c < 20 && idx < 8; c++) begin
            if (vld) begin
                chk($sformatf("bp_out%0d_op", idx), op,
                    (idx == 0) ? 4'h1 : (idx == 7) ? 4'h3 : 4'h2);
                chk($sformatf("bp_out%0d_val", idx), oval,
                    (idx == 0 || idx == 7) ? 32'h0 : 32'(idx) * 32'h1111);
                chk($sformatf("bp_out%0d_tag", idx), tag, 12'h0C1);
                idx++;
            end
            step(0, 64'h0);
        end
        chk("bp_drain_count", idx, 8);
        chk("bp_stall_released", stall, 0);
        chk("bp_err", err, 0);

        // Overflow: keep writing after stall with the FIFO full.
        rdy = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k == 0) step(1, w_desc(12'h0D2));
            else step(1, w_opt(4'h2, 32'(k)));
            if (k == 4) chk("ovf_stall_rise", stall, 1);
            if (k == 8) chk("ovf_err_full", err, 0);
        end
        chk("ovf_err", err, 1);
        chk("ovf_stall", stall, 1);
        rdy = 1'b1;
        step(0, 64'h0);
        chk("ovf_no_pop", vld, 0);
        chk("ovf_sticky", err, 1);
        en = 1'b0;
        step(0, 64'h0);
        en = 1'b1;
        chk("ovf_cleared", err, 0);

        // Async reset mid-descriptor with valid=1, ready=0.
        rdy = 1'b0;
        step(1, w_desc(12'h0E3));
        wvld = 1'b0;
        chk("ar_pre_valid", vld, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_valid", vld, 0);
        chk("ar_tag", tag, 0);
        chk("ar_op", op, 0);
        chk("ar_sop", sop, 0);
        chk("ar_stall", stall, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        rdy = 1'b1;
        step(0, 64'h0);
        chk("ar_after_valid", vld, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wu_decode.md
Name: wu_decode

Overview:
- Sits directly downstream of the WU memory read port that the WU fetch stage drives.
- Captures each returned WU word in a small skid FIFO and throttles the fetch stage through its stall input.
- Parses the word stream into descriptors (DESC header, OPTION words, END).
- Presents one decoded word per handshake to the manager dispatch logic; flags protocol errors and HALT to manager control.

Parameters:
- WU_DATA_WIDTH, 64: WU memory word width; field positions below assume 64.
- FIFO_DEPTH, 8: skid FIFO entries; power of 2, >= 4.
- SKID, 4: free entries reserved to absorb words already in flight after stall is raised.

Ports:
- clk  input  1  clock
- reset_poweron  input  1  asynchronous active-high reset
- mcntl__wud__enable  input  1  low = flush FIFO and return to IDLE; mirrors the fetch enable
- wum__wud__valid  input  1  WU memory read data valid this cycle
- wum__wud__data  input  WU_DATA_WIDTH  WU memory read data
- wud__wuf__stall  output  1  to fetch stall input; registered
- wud__xxx__valid  output  1  decoded word valid
- xxx__wud__ready  input  1  consumer accepts the word when valid & ready
- wud__xxx__op  output  4  word op
- wud__xxx__tag  output  12  descriptor tag; held for the whole descriptor
- wud__xxx__opt_type  output  4  option type; 0 when op is not OPTION
- wud__xxx__opt_value  output  32  option value; 0 when op is not OPTION
- wud__xxx__sop  output  1  first word of descriptor (DESC)
- wud__xxx__eop  output  1  last word of descriptor (END)
- wud__mcntl__err  output  1  sticky protocol or overflow error
- wud__mcntl__halted  output  1  HALT word consumed

Behaviour:
- Reset: all outputs 0; FIFO empty; state IDLE; tag register 0.
- Word format:
  - op = data[63:60]: 0 NOP, 1 DESC, 2 OPTION, 3 END, 15 HALT; all other values are illegal.
  - tag = [59:48], valid on DESC.
  - opt_type = [59:56], opt_value = [31:0], valid on OPTION.
- FIFO:
  - Write when wum__wud__valid. Pop when the head is decoded and either dropped (NOP) or accepted (valid & ready).
  - Simultaneous push and pop leaves occupancy unchanged.
  - A write while full drops the word and sets err.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits.
- Stall:
  - wud__wuf__stall <= (occupancy_next >= FIFO_DEPTH-SKID) | halted | err | state==HALTED.
  - Registered, 1-cycle latency from the occupancy change.
- Output stage:
  - Single register slice. Loads from the FIFO head when empty or when the current word is accepted, giving back-to-back throughput.
  - Outputs hold stable while valid & ~ready.
  - NOP words are popped without producing valid.
- FSM states: IDLE, IN_DESC, HALTED, ERR.
  - IDLE + DESC: emit with sop=1, latch tag, go to IN_DESC.
  - IDLE + HALT: emit once, set halted, go to HALTED.
  - IDLE + OPTION or END: go to ERR.
  - IN_DESC + OPTION: emit.
  - IN_DESC + END: emit with eop=1, go to IDLE.
  - IN_DESC + DESC or HALT: go to ERR.
  - Any state + illegal op: go to ERR.
  - HALTED: no pops; stall=1.
  - ERR: sticky until reset or enable low; no pops; stall=1; err=1. The offending word is not emitted.
- Transitions occur on word emission (the head entering the output slice), not on acceptance.
- mcntl__wud__enable low:
  - Synchronous flush of FIFO, output slice valid, FSM (to IDLE), err, halted; tag register is held.
  - Incoming words are discarded.
  - stall = 0 on the cycle after.
- Reset mid-descriptor or with the output slice valid: everything clears immediately (asynchronous). No partial descriptor is resumed.
- Latency: a word written at cycle N appears as wud__xxx__valid at N+1 when the FIFO is empty and ready=1 (fall-through to the output slice at N+1).

Test Plan:
- Basic descriptor: DESC tag=0x0A5, OPTION type=3 value=0x12345678, END, ready=1 → three valid cycles. sop on the first, eop on the third, tag=0x0A5 on all three, opt_value=0x12345678 on the second only.
- Back-pressure: ready=0 for 10 cycles while 8 words stream in → stall rises on the cycle after occupancy reaches 4. No word is lost. Outputs hold; all 8 emerge in order once ready=1.
- Overflow: words keep arriving for 5 cycles after stall rises with DEPTH=8 full → err=1, stall=1, the excess word is dropped.
- Protocol error: OPTION in IDLE → err=1 next cycle, no valid emitted, stall=1. Enable low for 1 cycle → err=0, state IDLE.
- NOP and HALT: DESC, NOP, END, HALT → exactly DESC, END, HALT emitted; halted=1 after HALT is accepted; stall stays 1.
- Async reset asserted mid-descriptor with valid=1 and ready=0 → all outputs 0 immediately, without waiting for a clock edge.
